// File: rtl/cm150_pkg.sv
// Shared definitions for the CM150 16:1 inverting-mux scan controller.
package cm150_pkg;

    localparam int CM150_N     = 16;
    localparam int CM150_SEL_W = 4;

    // Which bit of the select bus drives each mux select pin
    localparam int CM150_PIN_Q = 0;
    localparam int CM150_PIN_R = 1;
    localparam int CM150_PIN_S = 2;
    localparam int CM150_PIN_T = 3;

    typedef enum logic [1:0] {
        st_idle,
        st_chk,
        st_scan,
        st_hold
    } state_t;

    function automatic logic [CM150_SEL_W-1:0] sel_pins(input logic [CM150_SEL_W-1:0] idx);
        logic [CM150_SEL_W-1:0] p;
        p = '0;
        p[CM150_PIN_Q] = idx[0];
        p[CM150_PIN_R] = idx[1];
        p[CM150_PIN_S] = idx[2];
        p[CM150_PIN_T] = idx[3];
        return p;
    endfunction

endpackage

// File: rtl/cm150_settle_cnt.sv
// Settle counter: counts 0..SETTLE while enabled, ticks on the terminal count.
module cm150_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [3:0] settle_last = 4'(SETTLE);

    logic [3:0] cnt;

    assign tick = en && (cnt == settle_last);

    // Held at zero outside the scan so each scan starts from a clean count
    always_ff @(posedge clk) begin
        if (rst || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/cm150_scan_ctrl.sv
// Scan controller for the CM150 16:1 inverting mux: strobe check, 16-input
// scan with settle time, and a valid/ready word output.
//
// state   | meaning
// idle    | strobe high, waiting for start_i
// chk     | strobe high, mux output must read 1
// scan    | strobe low, stepping index 0..15 with settle
// hold    | word presented, waiting for ready_i
module cm150_scan_ctrl
    import cm150_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic [CM150_SEL_W-1:0] sel_o,
    output logic                   strobe_o,
    input  logic                   mux_i,
    output logic                   busy_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [CM150_N-1:0]     word_o,
    output logic                   err_o
);

    localparam logic [CM150_SEL_W-1:0] last_index = CM150_SEL_W'(CM150_N - 1);

    state_t                 state, state_nx;
    logic [CM150_SEL_W-1:0] index, index_nx;
    logic [CM150_SEL_W-1:0] sel_nx;
    logic                   strobe_nx;
    logic                   busy_nx;
    logic                   valid_nx;
    logic [CM150_N-1:0]     word_nx;
    logic                   err_nx;
    logic                   tick;

    cm150_settle_cnt #(
        .SETTLE(SETTLE)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .en   (state == st_scan),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_idle;
            index    <= '0;
            sel_o    <= '0;
            strobe_o <= 1'b1;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            word_o   <= '0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_nx;
            index    <= index_nx;
            sel_o    <= sel_nx;
            strobe_o <= strobe_nx;
            busy_o   <= busy_nx;
            valid_o  <= valid_nx;
            word_o   <= word_nx;
            err_o    <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        index_nx  = index;
        sel_nx    = sel_o;
        strobe_nx = strobe_o;
        busy_nx   = busy_o;
        valid_nx  = valid_o;
        word_nx   = word_o;
        err_nx    = err_o;

        case (state)
            st_idle: begin
                sel_nx    = '0;
                strobe_nx = 1'b1;
                if (start_i) begin
                    state_nx = st_chk;
                    busy_nx  = 1'b1;
                    err_nx   = 1'b0;
                end
            end

            st_chk: begin
                // With strobe high a healthy mux must output 1
                if (!mux_i) begin
                    err_nx = 1'b1;
                end
                state_nx  = st_scan;
                index_nx  = '0;
                sel_nx    = sel_pins('0);
                strobe_nx = 1'b0;
            end

            st_scan: begin
                if (tick) begin
                    word_nx[index] = ~mux_i;
                    if (index == last_index) begin
                        state_nx  = st_hold;
                        index_nx  = '0;
                        valid_nx  = 1'b1;
                        busy_nx   = 1'b0;
                        strobe_nx = 1'b1;
                        sel_nx    = '0;
                    end else begin
                        index_nx = index + 1'b1;
                        sel_nx   = sel_pins(index + 1'b1);
                    end
                end
            end

            st_hold: begin
                if (ready_i) begin
                    state_nx = st_idle;
                    valid_nx = 1'b0;
                end
            end

            default: begin
                state_nx = st_idle;
            end
        endcase
    end

endmodule

// File: tb/tb_cm150_scan_ctrl.sv
// Scoreboard bench for cm150_scan_ctrl at SETTLE=1 and SETTLE=0, each instance
// loaded by a behavioural CM150 mux.
module tb_cm150_scan_ctrl;
    import cm150_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [15:0] data;
    logic        fault;
    logic        k;          // 1: SETTLE=1 instance active, 0: SETTLE=0 instance
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [15:0] w;
        logic        e;
        int          c;
    } exp_t;
    exp_t exp_q[$];

    logic [3:0]  sel0, sel1;
    logic        strobe0, strobe1, mux0, mux1, busy0, busy1, valid0, valid1, err0, err1;
    logic [15:0] word0, word1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CM150: v = u | ~data[{t,s,r,q}]
    function automatic logic mux_model(input logic [3:0] sel, input logic u, input logic [15:0] d);
        logic [3:0] idx;
        idx = {sel[CM150_PIN_T], sel[CM150_PIN_S], sel[CM150_PIN_R], sel[CM150_PIN_Q]};
        return u | ~d[idx];
    endfunction

    assign mux1 = (fault && k)  ? 1'b0 : mux_model(sel1, strobe1, data);
    assign mux0 = (fault && !k) ? 1'b0 : mux_model(sel0, strobe0, data);

    cm150_scan_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start_i(start & k), .sel_o(sel1), .strobe_o(strobe1),
        .mux_i(mux1), .busy_o(busy1), .valid_o(valid1), .ready_i(ready),
        .word_o(word1), .err_o(err1)
    );

    cm150_scan_ctrl #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start_i(start & ~k), .sel_o(sel0), .strobe_o(strobe0),
        .mux_i(mux0), .busy_o(busy0), .valid_o(valid0), .ready_i(ready),
        .word_o(word0), .err_o(err0)
    );

    logic [3:0]  a_sel;
    logic        a_strobe, a_busy, a_valid, a_err;
    logic [15:0] a_word;
    assign a_sel    = k ? sel1    : sel0;
    assign a_strobe = k ? strobe1 : strobe0;
    assign a_busy   = k ? busy1   : busy0;
    assign a_valid  = k ? valid1  : valid0;
    assign a_err    = k ? err1    : err0;
    assign a_word   = k ? word1   : word0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rising valid must match the oldest outstanding scan
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (a_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected valid", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("word", a_word, e.w);
                check("err at valid", a_err, e.e);
                check("valid latency", cyc, e.c);
            end
        end
        prev_v <= a_valid;
    end

    // Issue a start; the expected word is the mux data, the error flag is the
    // injected strobe fault, and valid arrives 1+16*(SETTLE+1) edges after acceptance.
    task automatic do_start(input logic [15:0] d, input logic flt);
        exp_t e;
        int   settle;
        @(negedge clk);
        settle = k ? 1 : 0;
        data   = d;
        start  = 1'b1;
        e.w = d;
        e.e = flt;
        e.c = cyc + 2 + 16 * (settle + 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        fault = flt;
        check("busy after accept", a_busy, 1);
        check("err cleared on accept", a_err, 0);
        @(posedge clk);
        #1;
        fault = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_valid && n < budget);
        check("valid within budget", a_valid, 1);
    endtask

    initial begin
        logic [15:0] d;
        int          n;

        rst = 1'b1; start = 1'b0; ready = 1'b1; data = '0; fault = 1'b0; k = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset sel", sel1, 0);
        check("reset strobe", strobe1, 1);
        check("reset busy", busy1, 0);
        check("reset valid", valid1, 0);
        check("reset word", word1, 0);
        check("reset err", err1, 0);
        check("reset strobe s0", strobe0, 1);
        rst = 1'b0;

        // Basic scan, SETTLE=1
        do_start(16'hA5C3, 1'b0);
        wait_valid(60);
        @(posedge clk);
        #1;
        check("idle after ready", a_valid, 0);

        // Minimum settle, back-to-back
        @(negedge clk);
        k = 1'b0;
        do_start(16'hFFFF, 1'b0);
        wait_valid(40);
        do_start(16'h0000, 1'b0);
        wait_valid(40);

        // Backpressure with start during hold
        @(negedge clk);
        k = 1'b1;
        ready = 1'b0;
        d = 16'($urandom);
        do_start(d, 1'b0);
        wait_valid(60);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 3);
            check("hold word stable", a_word, d);
            check("hold valid stable", a_valid, 1);
            check("hold not busy", a_busy, 0);
        end
        start = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid drop after ready", a_valid, 0);
        check("strobe idle after ready", a_strobe, 1);
        repeat (5) @(negedge clk);
        check("no scan from hold start", a_busy, 0);

        // Start while busy, sampled at edge 5
        d = 16'($urandom);
        do_start(d, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(60);

        // Strobe fault in the check cycle
        @(negedge clk);
        ready = 1'b0;
        do_start(16'($urandom), 1'b1);
        wait_valid(60);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("err held in hold", a_err, 1);
        end
        ready = 1'b1;
        do_start(16'($urandom), 1'b0);
        wait_valid(60);

        // Reset in the middle of a scan
        do_start(16'($urandom), 1'b0);
        n = 0;
        while (a_sel != 4'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("sel reaches 7", a_sel, 7);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        check("rst strobe", a_strobe, 1);
        check("rst sel", a_sel, 0);
        check("rst busy", a_busy, 0);
        check("rst word", a_word, 0);
        check("rst valid", a_valid, 0);
        rst = 1'b0;
        do_start(16'($urandom), 1'b0);
        wait_valid(60);

        // Randomized scans on both instances with random consumer delay
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            k = 1'($urandom_range(0, 1));
            ready = 1'b0;
            do_start(16'($urandom), 1'b0);
            wait_valid(60);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ready = 1'b1;
        end

        repeat (5) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
